// File: rtl/serial_frame_deser.sv
// Start-bit framed serial receiver: WIDTH bits LSB-first, stop bit 0; SERIAL_FRAME_DESER_PARITY_EN adds an even-parity bit before the stop bit.
// Latency: out_valid rises on the stop-bit edge (WIDTH+1 edges after the start bit, one more with parity).
// Backpressure: the held word is never overwritten; a frame completing while it is unconsumed is dropped and sets sticky overrun.
module serial_frame_deser #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun,
    input  logic             clr_ovr
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic             load, drop, ferr_set;
`ifdef SERIAL_FRAME_DESER_PARITY_EN
    logic             perr_set;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        drop     = 1'b0;
        ferr_set = 1'b0;
`ifdef SERIAL_FRAME_DESER_PARITY_EN
        perr_set = 1'b0;
`endif
        case (state)
            IDLE: if (d) state_n = SHIFT;
            SHIFT: begin
                if (cnt == LAST) begin
`ifdef SERIAL_FRAME_DESER_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end
            end
`ifdef SERIAL_FRAME_DESER_PARITY_EN
            PARITY: begin
                // Bad parity drops the frame without looking at the stop bit
                if (d != ^sreg) begin
                    perr_set = 1'b1;
                    state_n  = IDLE;
                end else begin
                    state_n  = STOP;
                end
            end
`endif
            STOP: begin
                state_n = IDLE;
                if (d)                          ferr_set = 1'b1;
                else if (!out_valid || out_ready) load   = 1'b1;
                else                            drop     = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            sreg      <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (state == SHIFT) begin
                sreg[cnt] <= d;
                cnt       <= cnt + 1'b1;
            end else begin
                cnt       <= '0;
            end

            // A load on the same edge as a transfer keeps out_valid high
            if (load) begin
                data_out  <= sreg;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            frame_err <= ferr_set;

            if (drop)         overrun <= 1'b1;
            else if (clr_ovr) overrun <= 1'b0;
        end
    end

`ifdef SERIAL_FRAME_DESER_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) parity_err <= 1'b0;
        else        parity_err <= perr_set;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
